// File: rtl/jpegls_pixel_reconstruct.sv
// jpegls_pixel_reconstruct: regular-mode JPEG-LS decoder pixel reconstruction with per-context A/B/C/N statistics
module jpegls_pixel_reconstruct #(
  parameter int BPP = 12,
  parameter int T1 = 18,
  parameter int T2 = 67,
  parameter int T3 = 276,
  parameter int RESET_N = 64,
  parameter int A_W = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sof,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BPP-1:0] ra,
  input  logic [BPP-1:0] rb,
  input  logic [BPP-1:0] rc,
  input  logic [BPP-1:0] rd,
  output logic           k_valid,
  output logic [4:0]     k_out,
  input  logic           err_valid,
  output logic           err_ready,
  input  logic [BPP:0]   merr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BPP-1:0] rx_out
);
  typedef struct packed {
    logic [A_W-1:0]        a;
    logic signed [A_W-1:0] b;
    logic signed [7:0]     c;
    logic [6:0]            n;
  } ctx_t;
  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_CTX = 3'd2, S_PRED = 3'd3,
                         S_WAIT = 3'd4, S_RECON = 3'd5, S_OUT = 3'd6;
  localparam int A_INIT = (((1 << BPP) + 32) >> 6) < 2 ? 2 : (((1 << BPP) + 32) >> 6);
  localparam logic signed [BPP:0] T1S = (BPP+1)'(T1), T2S = (BPP+1)'(T2), T3S = (BPP+1)'(T3);
  logic [2:0] state;
  logic [8:0] cnt, q_r, q_idx;
  logic [BPP-1:0] ra_r, rb_r, rc_r, rd_r, px_r, mx, mn, px_c, rx_c;
  logic neg_r, half, lo, hi;
  logic signed [BPP:0] d1, d2, d3;
  logic signed [9:0] qf;
  logic signed [BPP+1:0] med, p_adj, e, ev_c, ev_r;
  logic [BPP+1:0] hm, ev_abs;
  logic [4:0] k_c;
  logic [A_W-1:0] a1;
  logic signed [A_W+1:0] b1, b2, b3, b4, nw2;
  logic [6:0] n2;
  logic signed [7:0] c_new;
  ctx_t mem [0:364];
  ctx_t cx, cx_new;
  function automatic logic signed [3:0] quant(input logic signed [BPP:0] d);
    return d <= -T3S ? -4'sd4 : d <= -T2S ? -4'sd3 : d <= -T1S ? -4'sd2 : d < 0 ? -4'sd1 :
           d == 0 ? 4'sd0 : d < T1S ? 4'sd1 : d < T2S ? 4'sd2 : d < T3S ? 4'sd3 : 4'sd4;
  endfunction
  assign in_ready  = state == S_IDLE;
  assign k_valid   = state == S_WAIT;
  assign err_ready = k_valid;
  assign out_valid = state == S_OUT;
  always_comb begin
    d1 = $signed({1'b0, rd_r}) - $signed({1'b0, rb_r});
    d2 = $signed({1'b0, rb_r}) - $signed({1'b0, rc_r});
    d3 = $signed({1'b0, rc_r}) - $signed({1'b0, ra_r});
    qf = 10'(quant(d1)) * 10'sd81 + 10'(quant(d2)) * 10'sd9 + 10'(quant(d3));
    q_idx = qf[9] ? 9'(-qf) : qf[8:0];
    mx = ra_r > rb_r ? ra_r : rb_r;
    mn = ra_r > rb_r ? rb_r : ra_r;
    med = rc_r >= mx ? (BPP+2)'(mn) : rc_r <= mn ? (BPP+2)'(mx) :
          (BPP+2)'(ra_r) + (BPP+2)'(rb_r) - (BPP+2)'(rc_r);
    p_adj = med + (neg_r ? -(BPP+2)'(cx.c) : (BPP+2)'(cx.c));
    px_c = p_adj[BPP+1] ? '0 : p_adj[BPP] ? '1 : p_adj[BPP-1:0];
    hm = ((BPP+2)'(merr) + (BPP+2)'(merr[0])) >> 1;
    e = merr[0] ? -$signed(hm) : $signed(hm);
    // -e-1 is the bitwise complement of e
    ev_c = k_out == '0 && ((A_W+2)'(cx.b) <<< 1) <= -$signed((A_W+2)'(cx.n)) ? ~e : e;
    rx_c = px_r + (neg_r ? -ev_r[BPP-1:0] : ev_r[BPP-1:0]);
    ev_abs = ev_r[BPP+1] ? (BPP+2)'(-ev_r) : ev_r;
    half = cx.n == 7'(RESET_N);
    a1 = cx.a + A_W'(ev_abs);
    b1 = (A_W+2)'(cx.b) + (A_W+2)'(ev_r);
    b2 = half ? b1 >>> 1 : b1;
    n2 = (half ? cx.n >> 1 : cx.n) + 7'd1;
    nw2 = $signed((A_W+2)'(n2));
    lo = b2 <= -nw2;
    hi = !b2[A_W+1] && b2 != '0;
    b3 = lo ? b2 + nw2 : hi ? b2 - nw2 : b2;
    b4 = lo && b3 <= -nw2 ? (A_W+2)'(1) - nw2 : hi && !b3[A_W+1] && b3 != '0 ? '0 : b3;
    c_new = lo && cx.c != 8'sh80 ? cx.c - 8'sd1 : hi && cx.c != 8'sh7f ? cx.c + 8'sd1 : cx.c;
    cx_new = '{a: half ? a1 >> 1 : a1, b: b4[A_W-1:0], c: c_new, n: n2};
  end
  always_comb begin
    k_c = 5'(BPP + 4);
    for (int i = BPP + 4; i >= 0; i--)
      k_c = ((A_W+BPP+4)'(cx.n) << i) >= (A_W+BPP+4)'(cx.a) ? 5'(i) : k_c;
  end
  always_ff @(posedge clk) begin
    if (state == S_INIT) mem[cnt] <= '{a: A_W'(A_INIT), b: '0, c: '0, n: 7'd1};
    else if (state == S_RECON) mem[q_r] <= cx_new;
    if (state == S_CTX) cx <= mem[q_idx];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt <= '0;
      {ra_r, rb_r, rc_r, rd_r, px_r} <= '0;
      q_r <= '0;
      neg_r <= 1'b0;
      ev_r <= '0;
      k_out <= '0;
      rx_out <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt == 9'd364 ? '0 : cnt + 9'd1;
          if (cnt == 9'd364) state <= S_IDLE;
        end
        S_IDLE: begin
          if (sof) state <= S_INIT;
          else if (in_valid) begin
            {ra_r, rb_r, rc_r, rd_r} <= {ra, rb, rc, rd};
            state <= S_CTX;
          end
        end
        S_CTX: begin
          q_r <= q_idx;
          neg_r <= qf[9];
          state <= S_PRED;
        end
        S_PRED: begin
          px_r <= px_c;
          k_out <= k_c;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (err_valid) begin
            ev_r <= ev_c;
            state <= S_RECON;
          end
        end
        S_RECON: begin
          rx_out <= rx_c;
          state <= S_OUT;
        end
        S_OUT: if (out_ready) state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end
endmodule
